rf_multiport: RTL and testbench
===============================

RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 SHALL have parameter WIDTH, default 64: entry width in bits.
REQ-002 SHALL have parameter LG_DEPTH, default 6: log2 of entry count; DEPTH = 1<<LG_DEPTH.
REQ-003 SHALL have parameter N_RD, default 6: number of read ports, range 1..8.
REQ-004 SHALL have parameter N_WR, default 3: number of write ports, range 1..4.
REQ-005 SHALL have parameter ZERO_REG, default 1: when 1, entry 0 ignores writes and always reads 0.
REQ-006 SHALL have parameter BYPASS, default 1: when 1, same-cycle writes forward to reads.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 rdptr  in  N_RD x LG_DEPTH  read addresses.
REQ-010 rd  out  N_RD x WIDTH  registered read data.
REQ-011 wrptr  in  N_WR x LG_DEPTH  write addresses.
REQ-012 wen  in  N_WR  write enables.
REQ-013 wr  in  N_WR x WIDTH  write data.
REQ-014 ready  out  1  high once the array is cleared; writes are accepted only while ready is high.
REQ-015 wr_conflict  out  1  registered pulse: two or more enabled write ports hit the same address.

Function
REQ-016 Read latency SHALL be exactly 1 cycle: rd[i] after edge t reflects rdptr[i] sampled at edge t.
REQ-017 Writes SHALL commit at the rising edge on which wen[j] is sampled high and ready is high.
REQ-018 When several enabled ports target one address, the highest-numbered port SHALL win.
REQ-019 wr_conflict SHALL be 1 for exactly the cycle after a multi-port address collision, and 0 otherwise; entry 0 collisions count even when ZERO_REG=1.
REQ-020 BYPASS=1: a read of an address written in the same cycle SHALL return the winning new data.
REQ-021 BYPASS=0: a read of an address written in the same cycle SHALL return the pre-write data.
REQ-022 ZERO_REG=1: rdptr==0 SHALL return 0, and writes to entry 0 SHALL be dropped, with no bypass.
REQ-023 The FSM SHALL have two states: INIT and RUN; reset forces INIT with clear counter 0.
REQ-024 In INIT with reset low, each cycle SHALL zero entry[cnt] and increment cnt (LG_DEPTH+1 bits).
REQ-025 INIT->RUN SHALL occur on the edge that clears entry DEPTH-1; ready SHALL be 1 from that edge on.
REQ-026 In INIT, writes SHALL be ignored and all rd outputs SHALL be 0.
REQ-027 In RUN, state SHALL persist until reset; there is no other exit.
REQ-028 Reset asserted mid-clear SHALL restart the clear from entry 0.

Reset
REQ-029 While reset is high: state=INIT, cnt=0, ready=0, wr_conflict=0, all rd=0, no array writes.
REQ-030 Array contents SHALL be all-zero when ready first rises, regardless of pre-reset contents.

Structure
REQ-031 Package rf_pkg SHALL hold the state enum typedef (RF_INIT, RF_RUN) and the N_RD/N_WR maximum constants.
REQ-032 Sub-module rf_wr_merge SHALL resolve per-address write priority, producing a winning enable/data and the collision flag; it is instantiated once and shared by the write and bypass paths.
REQ-033 Parameter values outside the stated ranges SHALL trigger an elaboration-time error.

Verification (WIDTH=64, LG_DEPTH=6, N_RD=6, N_WR=3 unless noted)
REQ-034 Release reset at edge 0 -> ready=0 through edge 63, ready=1 at edge 64; all rd=0 throughout.
REQ-035 RUN: port0 writes 0xDEAD to 5 at edge t while rdptr[3]=5 -> rd[3]=0xDEAD after t (BYPASS=1); old value 0 with BYPASS=0, then 0xDEAD after t+1.
REQ-036 Ports 0 and 2 write 0x11 and 0x22 to 7 at the same edge -> entry 7=0x22; wr_conflict=1 for one cycle only.
REQ-037 ZERO_REG=1: write 0xFF to entry 0 -> every read of entry 0 returns 0; no bypass of 0xFF.
REQ-038 Write 0xAB to 9, then assert reset for one cycle at clear count 30 -> ready rises 64 edges after release; entry 9 reads 0.
REQ-039 Drive wen=3'b111 during INIT -> no entry changes; entries still read 0 after ready rises.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and limits for the multiported register file.
package rf_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int MAX_N_RD = 8;
  localparam int MAX_N_WR = 4;

endpackage

// File: rtl/rf_wr_merge.sv
// Write-port priority resolver: a port wins unless a higher-numbered enabled
// port targets the same address. Also flags any multi-port address collision.
module rf_wr_merge #(
  parameter int WIDTH    = 64,
  parameter int LG_DEPTH = 6,
  parameter int N_WR     = 3
) (
  input  logic [N_WR-1:0][LG_DEPTH-1:0] wrptr,
  input  logic [N_WR-1:0]               wen,
  input  logic [N_WR-1:0][WIDTH-1:0]    wr,
  output logic [N_WR-1:0]               win,
  output logic [N_WR-1:0][WIDTH-1:0]    win_data,
  output logic                          collision
);

  always_comb begin
    win       = wen;
    collision = 1'b0;
    for (int j = 0; j < N_WR; j++) begin
      for (int k = j + 1; k < N_WR; k++) begin
        if (wen[j] && wen[k] && (wrptr[j] == wrptr[k])) begin
          win[j]    = 1'b0;
          collision = 1'b1;
        end
      end
    end
  end

  // Losers drive zero so bypass can OR-reduce across ports.
  always_comb begin
    for (int j = 0; j < N_WR; j++)
      win_data[j] = win[j] ? wr[j] : '0;
  end

endmodule

// File: rtl/rf_multiport.sv
// Multiported register file with self-clearing init sequence, optional
// hardwired-zero entry 0 and optional same-cycle write-to-read forwarding.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int LG_DEPTH = 6,
  parameter int N_RD     = 6,
  parameter int N_WR     = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_RD-1:0][LG_DEPTH-1:0] rdptr,
  output logic [N_RD-1:0][WIDTH-1:0]    rd,
  input  logic [N_WR-1:0][LG_DEPTH-1:0] wrptr,
  input  logic [N_WR-1:0]               wen,
  input  logic [N_WR-1:0][WIDTH-1:0]    wr,
  output logic                          ready,
  output logic                          wr_conflict
);

  localparam int DEPTH = 1 << LG_DEPTH;
  localparam logic [LG_DEPTH:0] LAST = (LG_DEPTH + 1)'(DEPTH - 1);

  if (N_RD < 1 || N_RD > MAX_N_RD) begin : g_bad_nrd
    $error("rf_multiport: N_RD out of range 1..8");
  end
  if (N_WR < 1 || N_WR > MAX_N_WR) begin : g_bad_nwr
    $error("rf_multiport: N_WR out of range 1..4");
  end
  if (ZERO_REG < 0 || ZERO_REG > 1 || BYPASS < 0 || BYPASS > 1) begin : g_bad_flag
    $error("rf_multiport: ZERO_REG and BYPASS must be 0 or 1");
  end
  if (WIDTH < 1 || LG_DEPTH < 1) begin : g_bad_geom
    $error("rf_multiport: WIDTH and LG_DEPTH must be at least 1");
  end

  rf_state_e                     state;
  logic [LG_DEPTH:0]             cnt;
  logic [WIDTH-1:0]              mem [DEPTH];

  logic [N_WR-1:0]               win;
  logic [N_WR-1:0][WIDTH-1:0]    win_data;
  logic                          collision;
  logic [N_RD-1:0]               byp_hit;
  logic [N_RD-1:0][WIDTH-1:0]    byp_data;

  rf_wr_merge #(
    .WIDTH    (WIDTH),
    .LG_DEPTH (LG_DEPTH),
    .N_WR     (N_WR)
  ) u_merge (
    .wrptr     (wrptr),
    .wen       (wen),
    .wr        (wr),
    .win       (win),
    .win_data  (win_data),
    .collision (collision)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RF_INIT;
      cnt         <= '0;
      ready       <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= (state == RF_RUN) && collision;
      case (state)
        RF_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= RF_RUN;
            ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Winners are unique per address, so port iteration order does not matter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == RF_INIT) begin
        mem[cnt[LG_DEPTH-1:0]] <= '0;
      end else begin
        for (int j = 0; j < N_WR; j++)
          if (win[j] && !(ZERO_REG != 0 && wrptr[j] == '0))
            mem[wrptr[j]] <= wr[j];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_RD; i++) begin
      byp_hit[i]  = 1'b0;
      byp_data[i] = '0;
      for (int j = 0; j < N_WR; j++) begin
        if (win[j] && wrptr[j] == rdptr[i]) begin
          byp_hit[i]  = 1'b1;
          byp_data[i] = byp_data[i] | win_data[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state == RF_INIT) begin
      rd <= '0;
    end else begin
      for (int i = 0; i < N_RD; i++) begin
        if (ZERO_REG != 0 && rdptr[i] == '0)
          rd[i] <= '0;
        else if (BYPASS != 0 && byp_hit[i])
          rd[i] <= byp_data[i];
        else
          rd[i] <= mem[rdptr[i]];
      end
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: two instances (default config, and
// BYPASS=0/ZERO_REG=0) share stimulus and are checked against an array model.
module tb_rf_multiport;

  localparam int W     = 64;
  localparam int LG    = 6;
  localparam int NR    = 6;
  localparam int NW    = 3;
  localparam int DEPTH = 1 << LG;

  typedef struct {
    logic [NR-1:0][W-1:0] rd;
    logic                 ready;
    logic                 conf;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR-1:0][LG-1:0]  rdptr;
  logic [NW-1:0][LG-1:0]  wrptr;
  logic [NW-1:0]          wen;
  logic [NW-1:0][W-1:0]   wr;
  logic [NR-1:0][W-1:0]   rd0, rd1;
  logic                   ready0, ready1, conf0, conf1;

  exp_t     q0[$];
  exp_t     q1[$];
  logic [W-1:0] ref_mem [2][DEPTH];
  int       m_left [2];
  bit       m_ready [2];
  int       n_tests = 0;
  int       n_fail  = 0;

  always #5 clk = ~clk;

  rf_multiport dut0 (
    .clk(clk), .reset(reset), .rdptr(rdptr), .rd(rd0), .wrptr(wrptr),
    .wen(wen), .wr(wr), .ready(ready0), .wr_conflict(conf0)
  );

  rf_multiport #(.ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .rdptr(rdptr), .rd(rd1), .wrptr(wrptr),
    .wen(wen), .wr(wr), .ready(ready1), .wr_conflict(conf1)
  );

  // Reference: config 0 = ZERO_REG=1/BYPASS=1, config 1 = ZERO_REG=0/BYPASS=0.
  task automatic model();
    for (int c = 0; c < 2; c++) begin
      exp_t e;
      logic [W-1:0] nm [DEPTH];
      bit zr, byp;
      zr = (c == 0);
      byp = (c == 0);
      e.rd = '0; e.ready = 1'b0; e.conf = 1'b0;
      if (reset) begin
        m_left[c] = DEPTH;
        m_ready[c] = 1'b0;
      end else if (!m_ready[c]) begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          m_ready[c] = 1'b1;
          for (int a = 0; a < DEPTH; a++) ref_mem[c][a] = '0;
        end
        e.ready = m_ready[c];
      end else begin
        e.ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) nm[a] = ref_mem[c][a];
        for (int j = 0; j < NW; j++)
          if (wen[j] && !(zr && wrptr[j] == 0)) nm[wrptr[j]] = wr[j];
        for (int j = 0; j < NW; j++)
          for (int k = j + 1; k < NW; k++)
            if (wen[j] && wen[k] && wrptr[j] == wrptr[k]) e.conf = 1'b1;
        for (int i = 0; i < NR; i++) begin
          if (zr && rdptr[i] == 0) e.rd[i] = '0;
          else e.rd[i] = byp ? nm[rdptr[i]] : ref_mem[c][rdptr[i]];
        end
        for (int a = 0; a < DEPTH; a++) ref_mem[c][a] = nm[a];
      end
      if (c == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic check(input int d, input logic [NR-1:0][W-1:0] rd_a,
                       input logic rdy_a, input logic cf_a, input exp_t e);
    n_tests++;
    if (rdy_a !== e.ready) begin
      n_fail++;
      $display("FAIL ready dut%0d t=%0t got %b want %b", d, $time, rdy_a, e.ready);
    end
    n_tests++;
    if (cf_a !== e.conf) begin
      n_fail++;
      $display("FAIL wr_conflict dut%0d t=%0t got %b want %b", d, $time, cf_a, e.conf);
    end
    for (int i = 0; i < NR; i++) begin
      n_tests++;
      if (rd_a[i] !== e.rd[i]) begin
        n_fail++;
        $display("FAIL rd[%0d] dut%0d t=%0t got %h want %h", i, d, $time, rd_a[i], e.rd[i]);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) check(0, rd0, ready0, conf0, q0.pop_front());
    if (q1.size() > 0) check(1, rd1, ready1, conf1, q1.pop_front());
  end

  // Inputs change at negedge; the model predicts the next posedge's outputs.
  task automatic cyc();
    model();
    @(negedge clk);
  endtask

  task automatic idle();
    wen = '0;
    wr  = '0;
    for (int i = 0; i < NR; i++) rdptr[i] = LG'($urandom_range(0, DEPTH - 1));
    for (int j = 0; j < NW; j++) wrptr[j] = LG'($urandom_range(0, DEPTH - 1));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    repeat (3) cyc();

    // Clear sequence with every write port enabled at distinct addresses.
    reset = 1'b0;
    for (int n = 0; n < DEPTH + 2; n++) begin
      idle();
      wen = '1;
      for (int j = 0; j < NW; j++) begin
        wrptr[j] = LG'(3 * n + j);
        wr[j]    = {$urandom, $urandom};
      end
      cyc();
    end

    // Forwarding: write 0xDEAD to 5 while port 3 reads 5, then re-read.
    idle();
    rdptr[3] = LG'(5); wrptr[0] = LG'(5); wen[0] = 1'b1; wr[0] = 64'hDEAD;
    cyc();
    idle();
    rdptr[3] = LG'(5);
    cyc();

    // Collision on entry 7, then a quiet cycle read of 7.
    idle();
    wrptr[0] = LG'(7); wrptr[2] = LG'(7); wrptr[1] = LG'(8);
    wen = 3'b101; wr[0] = 64'h11; wr[2] = 64'h22;
    rdptr[0] = LG'(7);
    cyc();
    idle();
    rdptr[0] = LG'(7); rdptr[1] = LG'(7);
    cyc();
    cyc();

    // Entry 0 write with all ports reading 0.
    idle();
    wrptr[1] = '0; wen[1] = 1'b1; wr[1] = 64'hFF;
    rdptr = '0;
    cyc();
    idle();
    rdptr = '0;
    cyc();

    // Write 9, then reset mid-clear at count 30.
    idle();
    wrptr[2] = LG'(9); wen[2] = 1'b1; wr[2] = 64'hAB;
    cyc();
    idle();
    rdptr[5] = LG'(9);
    cyc();
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (30) begin idle(); cyc(); end
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
    for (int n = 0; n < DEPTH + 2; n++) begin
      idle();
      rdptr[0] = LG'(9);
      cyc();
    end

    // Random traffic over a small address window for frequent hits.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) rdptr[i] = LG'($urandom_range(0, 7));
      for (int j = 0; j < NW; j++) begin
        wrptr[j] = LG'($urandom_range(0, 7));
        wr[j]    = {$urandom, $urandom};
      end
      wen = NW'($urandom);
      cyc();
    end

    idle();
    repeat (3) @(negedge clk);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d/%0d pending want 0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
